// File: rtl/res_ascii_fmt_if.sv
// rtl/res_ascii_fmt_if.sv - result-word input strobe and ASCII byte stream to UART TX
interface res_ascii_fmt_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_signed;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  in_valid, in_data, in_signed, tx_ready,
    output tx_data, tx_valid
  );

  modport master (
    output in_valid, in_data, in_signed, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/res_ascii_fmt.sv
// rtl/res_ascii_fmt.sv - 32-bit result to decimal ASCII via 1-bit-per-cycle double-dabble
module res_ascii_fmt #(
  parameter bit         TERM_EN = 1'b1,
  parameter logic [7:0] TERM0   = 8'h0D,
  parameter logic [7:0] TERM1   = 8'h0A
) (
  input  logic            clk,
  input  logic            rst,
  res_ascii_fmt_if.slave  io,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_DONE} state_t;
  typedef enum logic [1:0] {P_SIGN, P_DIG, P_T0, P_T1} phase_t;

  state_t      state;
  phase_t      phase, nxt_phase;
  logic        neg;
  logic [31:0] mag;
  logic [39:0] bcd, bcd_adj, bcd_nx;
  logic [5:0]  cnt;
  logic [3:0]  dptr, nxt_dptr, msd, nib;
  logic        nxt_end;
  logic [7:0]  cur_byte, nxt_byte;

  function automatic logic [7:0] byte_of(input phase_t p, input logic [3:0] dig);
    case (p)
      P_SIGN:  byte_of = 8'h2D;
      P_DIG:   byte_of = 8'h30 + {4'h0, dig};
      P_T0:    byte_of = TERM0;
      default: byte_of = TERM1;
    endcase
  endfunction

  // One double-dabble step; msd is taken from the post-step value so it is
  // correct on the final CONV cycle when the pointer gets loaded.
  always_comb begin
    bcd_adj = '0;
    nib     = '0;
    for (int i = 0; i < 10; i++) begin
      nib = bcd[i*4 +: 4];
      bcd_adj[i*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    bcd_nx = {bcd_adj[38:0], mag[31]};
    msd = '0;
    for (int i = 1; i < 10; i++) begin
      if (bcd_nx[i*4 +: 4] != 4'd0) msd = 4'(i);
    end
  end

  always_comb begin
    nxt_phase = phase;
    nxt_dptr  = dptr;
    nxt_end   = 1'b0;
    case (phase)
      P_SIGN: nxt_phase = P_DIG;
      P_DIG: begin
        if (dptr != 4'd0)  nxt_dptr  = dptr - 4'd1;
        else if (TERM_EN)  nxt_phase = P_T0;
        else               nxt_end   = 1'b1;
      end
      P_T0:    nxt_phase = P_T1;
      default: nxt_end   = 1'b1;
    endcase
    cur_byte = byte_of(phase, bcd[{dptr, 2'b00} +: 4]);
    nxt_byte = byte_of(nxt_phase, bcd[{nxt_dptr, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= P_SIGN;
      neg         <= 1'b0;
      mag         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      dptr        <= '0;
      io.tx_data  <= 8'h00;
      io.tx_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (io.in_valid) begin
            neg   <= io.in_signed & io.in_data[31];
            mag   <= (io.in_signed & io.in_data[31]) ? (~io.in_data + 32'd1) : io.in_data;
            bcd   <= '0;
            cnt   <= 6'd32;
            busy  <= 1'b1;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          bcd <= bcd_nx;
          mag <= {mag[30:0], 1'b0};
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            dptr  <= msd;
            phase <= neg ? P_SIGN : P_DIG;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!io.tx_valid) begin
            io.tx_data  <= cur_byte;
            io.tx_valid <= 1'b1;
          end else if (io.tx_ready) begin
            if (nxt_end) begin
              io.tx_valid <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end else begin
              io.tx_data <= nxt_byte;
              phase      <= nxt_phase;
              dptr       <= nxt_dptr;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_ascii_fmt.sv
// tb/tb_res_ascii_fmt.sv - directed vectors for res_ascii_fmt, default and no-terminator builds
module tb_res_ascii_fmt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_a, done_a, busy_b, done_b;

  res_ascii_fmt_if a();
  res_ascii_fmt_if b();

  res_ascii_fmt dut_a (.clk(clk), .rst(rst), .io(a), .busy(busy_a), .done(done_a));
  res_ascii_fmt #(.TERM_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .io(b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] got[16];
  int got_n, first_lat, done_cyc, last_acc, stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one word into dut_a and collects its bytes; mode 1 grants tx_ready one cycle in three.
  task automatic run_word(input logic sgn, input logic [31:0] val, input int mode);
    int cyc;
    logic rdy, have_prev;
    logic [7:0] prev;
    @(negedge clk);
    a.in_valid = 1'b1; a.in_signed = sgn; a.in_data = val;
    @(negedge clk);
    a.in_valid = 1'b0;
    cyc = 1; got_n = 0; first_lat = -1; done_cyc = -1; last_acc = -1;
    stall_bad = 0; have_prev = 1'b0; prev = 8'h00;
    while (cyc < 600) begin
      if (a.tx_valid && first_lat < 0) first_lat = cyc;
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      a.tx_ready = rdy;
      if (have_prev && a.tx_valid && a.tx_data != prev) stall_bad++;
      have_prev = a.tx_valid && !rdy;
      prev = a.tx_data;
      if (a.tx_valid && rdy) begin
        if (got_n < 16) got[got_n] = a.tx_data;
        got_n++;
        last_acc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    a.tx_ready = 1'b0;
    chk("first_valid_latency", first_lat, 34);
    chk("done_after_last_byte", done_cyc, last_acc + 1);
  endtask

  task automatic expect_bytes(input string tag, input string s, input bit term);
    int n;
    logic [7:0] e;
    n = s.len() + (term ? 2 : 0);
    chk({tag, " len"}, got_n, n);
    for (int i = 0; i < n && i < got_n && i < 16; i++) begin
      if (i < s.len()) e = s[i];
      else e = (i == s.len()) ? 8'h0D : 8'h0A;
      chk($sformatf("%s b%0d", tag, i), got[i], e);
    end
  endtask

  initial begin
    int vld_cnt, wait_n;
    a.in_valid = 1'b0; a.in_data = '0; a.in_signed = 1'b0; a.tx_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_signed = 1'b0; b.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tx_data", a.tx_data, 8'h00);
    chk("rst tx_valid", a.tx_valid, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    rst = 1'b0;
    @(negedge clk);

    run_word(1'b0, 32'h0, 0);
    expect_bytes("u0", "0", 1);
    @(negedge clk);
    chk("done one cycle", done_a, 0);
    chk("idle busy", busy_a, 0);

    run_word(1'b1, 32'h0, 0);          expect_bytes("s0", "0", 1);
    run_word(1'b1, 32'hFFFF_FFFF, 0);  expect_bytes("s_m1", "-1", 1);
    run_word(1'b0, 32'hFFFF_FFFF, 0);  expect_bytes("u_max", "4294967295", 1);
    run_word(1'b1, 32'h8000_0000, 0);  expect_bytes("s_min", "-2147483648", 1);
    run_word(1'b1, 32'h0001_E240, 0);  expect_bytes("s_123456", "123456", 1);

    run_word(1'b0, 32'd907, 1);
    expect_bytes("stall_907", "907", 1);
    chk("stall stable", stall_bad, 0);

    // Re-pulses during CONV and EMIT must be dropped.
    fork
      run_word(1'b0, 32'd42, 1);
      begin
        repeat (10) @(negedge clk);
        a.in_valid = 1'b1; a.in_data = 32'd7;
        @(negedge clk);
        a.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        a.in_valid = 1'b1; a.in_data = 32'd8;
        @(negedge clk);
        a.in_valid = 1'b0;
      end
    join
    expect_bytes("repulse", "42", 1);
    // run_word returns in the DONE cycle: a strobe here is ignored too.
    a.in_valid = 1'b1; a.in_data = 32'd9;
    @(negedge clk);
    a.in_valid = 1'b0;
    chk("done-cycle strobe busy", busy_a, 0);
    vld_cnt = 0;
    a.tx_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (a.tx_valid || busy_a) vld_cnt++;
    end
    a.tx_ready = 1'b0;
    chk("done-cycle strobe ignored", vld_cnt, 0);

    // TERM_EN=0 build.
    @(negedge clk);
    b.in_valid = 1'b1; b.in_signed = 1'b1; b.in_data = 32'd5; b.tx_ready = 1'b1;
    @(negedge clk);
    b.in_valid = 1'b0;
    got_n = 0; done_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      if (done_b) begin
        done_cyc = i;
        break;
      end
      if (b.tx_valid) begin
        if (got_n < 16) got[got_n] = b.tx_data;
        got_n++;
      end
      @(negedge clk);
    end
    chk("noterm done seen", done_cyc >= 0, 1);
    expect_bytes("noterm", "5", 0);

    // Reset in the middle of EMIT.
    @(negedge clk);
    a.in_valid = 1'b1; a.in_signed = 1'b0; a.in_data = 32'd12345;
    @(negedge clk);
    a.in_valid = 1'b0;
    wait_n = 0;
    while (!a.tx_valid && wait_n < 60) begin
      @(negedge clk);
      wait_n++;
    end
    chk("pre-rst tx_valid", a.tx_valid, 1);
    chk("pre-rst tx_data", a.tx_data, 8'h31);
    rst = 1'b1;
    #1;
    chk("rst async tx_valid", a.tx_valid, 0);
    chk("rst async busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    vld_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_a || a.tx_valid) vld_cnt++;
    end
    chk("no done after rst", vld_cnt, 0);
    run_word(1'b0, 32'd1000, 0);
    expect_bytes("post_rst", "1000", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
